vectored_int_ctrl: RTL and testbench

VECTORED_INT_CTRL -- requirements
Module: vectored_int_ctrl

---
 rtl/vectored_int_ctrl.sv | 124 ++++++++++++
 tb/tb_vectored_int_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vectored_int_ctrl.sv
// rtl/vectored_int_ctrl.sv - vectored interrupt controller with fixed priority and single-level service
module vectored_int_ctrl #(
   parameter int                 NUM_IRQ    = 4,
   parameter int                 ID_W       = 2,
   parameter logic [31:0]        VEC_BASE   = 32'd512,
   parameter logic [31:0]        VEC_STRIDE = 32'd16,
   parameter logic [NUM_IRQ-1:0] EDGE_MODE  = '1,
   parameter logic [NUM_IRQ-1:0] RESET_MASK = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   input  logic               int_take,
   input  logic               isr_ret,
   output logic               int_req,
   output logic [ID_W-1:0]    int_id,
   output logic [31:0]        int_vec,
   output logic               in_service,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic [NUM_IRQ-1:0] pending_o,
   output logic [NUM_IRQ-1:0] mask_o
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t             state;
   logic [NUM_IRQ-1:0] sync1, sync2, sync3;
   logic [NUM_IRQ-1:0] pending, mask;
   logic [NUM_IRQ-1:0] eligible, rise, id_onehot, take_clr;
   logic [ID_W-1:0]    win_id;
   logic               any_elig, latched_ok, take_now;

   assign eligible   = pending & ~mask;
   assign rise       = sync2 & ~sync3;
   assign id_onehot  = NUM_IRQ'(1) << int_id;
   assign latched_ok = |(eligible & id_onehot);
   assign any_elig   = |eligible;
   // An accepted take wins over a same-cycle loss of eligibility: the CPU already saw int_req high.
   assign take_now   = (state == REQ) && int_take;
   assign take_clr   = take_now ? (id_onehot & EDGE_MODE) : '0;
   assign pending_o  = pending;
   assign mask_o     = mask;

   // Fixed priority: lowest-index eligible channel wins.
   always_comb begin
      win_id = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) win_id = ID_W'(i);
      end
   end

   // Two-flop synchronizer plus a previous-value flop for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= irq_in;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // Edge channels latch until taken (a new edge beats the clear); level channels follow sync2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pending <= '0;
      else       pending <= (EDGE_MODE & (rise | (pending & ~take_clr))) | (~EDGE_MODE & sync2);
   end

   // Mask register; masking never touches pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        mask <= RESET_MASK;
      else if (mask_we) mask <= mask_wdata;
   end

   // Request/service FSM with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         int_req    <= 1'b0;
         in_service <= 1'b0;
         int_id     <= '0;
         int_vec    <= VEC_BASE;
         irq_ack    <= '0;
      end else begin
         irq_ack <= '0;
         case (state)
            IDLE: begin
               if (any_elig) begin
                  state   <= REQ;
                  int_req <= 1'b1;
                  int_id  <= win_id;
                  int_vec <= VEC_BASE + VEC_STRIDE * 32'(win_id);
               end
            end
            REQ: begin
               if (int_take) begin
                  state      <= SERVICE;
                  int_req    <= 1'b0;
                  in_service <= 1'b1;
               end else if (!latched_ok) begin
                  state   <= IDLE;
                  int_req <= 1'b0;
               end
            end
            SERVICE: begin
               if (isr_ret) begin
                  state      <= IDLE;
                  in_service <= 1'b0;
                  irq_ack    <= id_onehot;
               end
            end
            default: begin
               state   <= IDLE;
               int_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// tb/tb_vectored_int_ctrl.sv - scoreboard testbench for vectored_int_ctrl
module tb_vectored_int_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [3:0]  irq, mask_wdata, irq_b, mask_wdata_b;
   logic        mask_we, int_take, isr_ret, mask_we_b, int_take_b, isr_ret_b;
   logic        int_req, in_service, int_req_b, in_service_b;
   logic [1:0]  int_id, int_id_b;
   logic [31:0] int_vec, int_vec_b;
   logic [3:0]  irq_ack, pending_o, mask_o, irq_ack_b, pending_o_b, mask_o_b;

   vectored_int_ctrl dut (
      .clk(clk), .reset(reset), .irq_in(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .int_take(int_take), .isr_ret(isr_ret), .int_req(int_req), .int_id(int_id),
      .int_vec(int_vec), .in_service(in_service), .irq_ack(irq_ack),
      .pending_o(pending_o), .mask_o(mask_o));

   vectored_int_ctrl #(.EDGE_MODE(4'b1110), .RESET_MASK(4'b1000)) dut_b (
      .clk(clk), .reset(reset), .irq_in(irq_b), .mask_we(mask_we_b), .mask_wdata(mask_wdata_b),
      .int_take(int_take_b), .isr_ret(isr_ret_b), .int_req(int_req_b), .int_id(int_id_b),
      .int_vec(int_vec_b), .in_service(in_service_b), .irq_ack(irq_ack_b),
      .pending_o(pending_o_b), .mask_o(mask_o_b));

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {int id; logic [31:0] vec;} req_t;
   req_t       req_q[$];
   logic [3:0] ack_q[$];
   req_t       mon_e;
   logic [3:0] mon_a;
   logic       prev_req = 1'b0;

   function automatic logic [31:0] ref_vec(input int id);
      return 32'd512 + 32'(16 * id);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every new request and every acknowledge is matched against the scoreboard.
   always @(negedge clk) begin
      if (int_req && !prev_req) begin
         if (req_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_req: got id %0d expected no request", int_id);
         end else begin
            mon_e = req_q.pop_front();
            chk("req_id", int_id, mon_e.id);
            chk("req_vec", int_vec, mon_e.vec);
         end
      end
      prev_req <= int_req;
      if (irq_ack != 4'b0) begin
         if (ack_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_ack: got %b expected 0000", irq_ack);
         end else begin
            mon_a = ack_q.pop_front();
            chk("irq_ack", irq_ack, mon_a);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_req(input int id);
      req_t e;
      e.id  = id;
      e.vec = ref_vec(id);
      req_q.push_back(e);
   endtask

   task automatic push_ack(input int id);
      ack_q.push_back(4'(1 << id));
   endtask

   task automatic wait_req(input bit b);
      int cnt = 0;
      while ((b ? int_req_b : int_req) !== 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      if (cnt >= 100) begin
         n_tests++; n_fail++;
         $display("FAIL req_timeout: got int_req 0 expected 1 within 100 cycles");
      end
   endtask

   task automatic take(input bit b);
      if (b) int_take_b = 1'b1; else int_take = 1'b1;
      tick();
      int_take = 1'b0; int_take_b = 1'b0;
   endtask

   task automatic ret(input bit b);
      if (b) isr_ret_b = 1'b1; else isr_ret = 1'b1;
      tick();
      isr_ret = 1'b0; isr_ret_b = 1'b0;
   endtask

   task automatic set_mask(input logic [3:0] m);
      mask_we = 1'b1; mask_wdata = m;
      tick();
      mask_we = 1'b0;
   endtask

   task automatic chk_reset_state();
      chk("rst_int_req", int_req, 0);
      chk("rst_in_service", in_service, 0);
      chk("rst_int_id", int_id, 0);
      chk("rst_int_vec", int_vec, 512);
      chk("rst_irq_ack", irq_ack, 0);
      chk("rst_pending", pending_o, 0);
      chk("rst_mask", mask_o, 0);
      chk("rst_mask_b", mask_o_b, 4'b1000);
   endtask

   task automatic serve(input int count);
      for (int k = 0; k < count; k++) begin
         wait_req(0);
         tick($urandom_range(0, 3));
         take(0);
         tick($urandom_range(0, 3));
         ret(0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] set, m, rest;
      int         cnt;
      reset = 1'b1;
      irq = '0; mask_we = 0; mask_wdata = '0; int_take = 0; isr_ret = 0;
      irq_b = '0; mask_we_b = 0; mask_wdata_b = '0; int_take_b = 0; isr_ret_b = 0;
      #1;
      chk_reset_state();
      tick(2);
      reset = 1'b0;
      tick(2);

      // Single edge on channel 2: latency and take.
      push_req(2); push_ack(2);
      irq = 4'b0100;
      tick(); tick();
      chk("lat_pending_e1", pending_o, 0);
      tick();
      chk("lat_pending_e2", pending_o, 4'b0100);
      chk("lat_req_e2", int_req, 0);
      tick();
      chk("lat_req_e3", int_req, 1);
      chk("lat_vec_e3", int_vec, 544);
      take(0);
      chk("take_pending", pending_o, 0);
      chk("take_in_service", in_service, 1);
      chk("take_req", int_req, 0);
      irq = '0;
      ret(0);
      chk("ret_in_service", in_service, 0);
      tick(3);

      // Channels 1 and 3 together: priority then the second one.
      push_req(1); push_ack(1); push_req(3); push_ack(3);
      irq = 4'b1010;
      wait_req(0);
      take(0);
      ret(0);
      chk("ack_pulse", irq_ack, 4'b0010);
      tick();
      chk("ack_one_cycle", irq_ack, 0);
      wait_req(0);
      chk("second_id", int_id, 3);
      take(0);
      irq = '0;
      ret(0);
      tick(3);

      // Masking the latched channel drops the request but keeps pending.
      push_req(0);
      irq = 4'b0001;
      wait_req(0);
      irq = '0;
      set_mask(4'b0001);
      chk("mask_applied", mask_o, 4'b0001);
      chk("mask_req_hold", int_req, 1);
      tick();
      chk("mask_req_drop", int_req, 0);
      chk("mask_pending_kept", pending_o, 4'b0001);
      push_req(0); push_ack(0);
      set_mask(4'b0000);
      tick();
      chk("unmask_req", int_req, 1);
      take(0);
      ret(0);
      tick(3);

      // Re-edge during service: no nesting, re-request after return.
      push_req(0); push_ack(0);
      irq = 4'b0001;
      wait_req(0);
      take(0);
      irq = '0;
      tick(3);
      irq = 4'b0001;
      tick(4);
      chk("svc_no_nest", int_req, 0);
      chk("svc_pending", pending_o, 4'b0001);
      chk("svc_in_service", in_service, 1);
      push_req(0); push_ack(0);
      ret(0);
      chk("svc_ret_idle", int_req, 0);
      wait_req(0);
      take(0);
      irq = '0;
      ret(0);
      tick(3);

      // Reset during service: abort without ack, held line is re-detected.
      push_req(1);
      irq = 4'b0010;
      wait_req(0);
      take(0);
      tick(2);
      reset = 1'b1;
      #1;
      chk_reset_state();
      push_req(1); push_ack(1);
      tick(2);
      reset = 1'b0;
      wait_req(0);
      take(0);
      irq = '0;
      ret(0);
      tick(3);

      // Level channel 0 on the second instance.
      irq_b = 4'b0001;
      wait_req(1);
      chk("lvl_id", int_id_b, 0);
      chk("lvl_vec", int_vec_b, 512);
      take(1);
      chk("lvl_pending_kept", pending_o_b, 4'b0001);
      chk("lvl_in_service", in_service_b, 1);
      ret(1);
      chk("lvl_ack", irq_ack_b, 4'b0001);
      wait_req(1);
      chk("lvl_rereq_id", int_id_b, 0);
      take(1);
      irq_b = '0;
      tick(4);
      chk("lvl_pending_low", pending_o_b, 0);
      ret(1);
      tick(4);
      chk("lvl_no_rereq", int_req_b, 0);

      // Randomized phases: ascending service of unmasked set, then drain masked.
      for (int p = 0; p < 20; p++) begin
         set = 4'($urandom_range(1, 15));
         m   = 4'($urandom_range(0, 15));
         set_mask(m);
         cnt = 0;
         for (int i = 0; i < 4; i++) if (set[i] && !m[i]) begin push_req(i); push_ack(i); cnt++; end
         irq = set;
         tick(4);
         irq = '0;
         serve(cnt);
         tick(2);
         chk("rand_pending_masked", pending_o, set & m);
         rest = set & m;
         if (rest != 4'b0) begin
            cnt = 0;
            for (int i = 0; i < 4; i++) if (rest[i]) begin push_req(i); push_ack(i); cnt++; end
            set_mask(4'b0000);
            serve(cnt);
         end
         tick(3);
      end

      tick(5);
      chk("req_q_empty", req_q.size(), 0);
      chk("ack_q_empty", ack_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
